// File: rtl/axil_resp_mem.sv
// AXI4-Lite slave backed by a word-addressed on-chip RAM.
// Independent read and write FSMs, one transaction outstanding per channel, OKAY/SLVERR by address decode.
module axil_resp_mem #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h7000_0000),
    parameter int unsigned           DEPTH_WORDS = 256
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_axi_aw_addr,
    input  logic [2:0]                s_axi_aw_prot,
    input  logic                      s_axi_aw_valid,
    output logic                      s_axi_aw_ready,
    input  logic [DATA_WIDTH-1:0]     s_axi_w_data,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_w_strb,
    input  logic                      s_axi_w_valid,
    output logic                      s_axi_w_ready,
    output logic [1:0]                s_axi_b_resp,
    output logic                      s_axi_b_valid,
    input  logic                      s_axi_b_ready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_ar_addr,
    input  logic [2:0]                s_axi_ar_prot,
    input  logic                      s_axi_ar_valid,
    output logic                      s_axi_ar_ready,
    output logic [DATA_WIDTH-1:0]     s_axi_r_data,
    output logic [1:0]                s_axi_r_resp,
    output logic                      s_axi_r_valid,
    input  logic                      s_axi_r_ready,
    output logic [15:0]               wr_count
);

    localparam int unsigned           STRB_W = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(4 * DEPTH_WORDS);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_MEM = 2'd1, R_RESP = 2'd2} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    wstate_t               r_wstate, w_wstate_nxt;
    logic                  r_aw_lat, r_w_lat, w_aw_lat_nxt, w_w_lat_nxt;
    logic                  r_aw_ready, r_w_ready, w_aw_ready_nxt, w_w_ready_nxt;
    logic                  r_b_valid, w_b_valid_nxt;
    logic [1:0]            r_b_resp, w_b_resp_nxt;
    logic [15:0]           r_wr_count;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;

    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_ar_ready, w_ar_ready_nxt;
    logic                  r_r_valid, w_r_valid_nxt;
    logic [1:0]            r_r_resp, w_r_resp_nxt;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic [ADDR_WIDTH-1:0] r_ar_addr;

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_aw_have, w_w_have;
    logic [ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
    logic                  w_wr_in_range, w_rd_in_range;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic                  w_mem_we;
    logic                  w_unused;

    assign w_aw_hs   = s_axi_aw_valid & r_aw_ready;
    assign w_w_hs    = s_axi_w_valid  & r_w_ready;
    assign w_ar_hs   = s_axi_ar_valid & r_ar_ready;
    assign w_aw_have = r_aw_lat | w_aw_hs;
    assign w_w_have  = r_w_lat  | w_w_hs;

    // Address decode on the latched addresses; addr[1:0] never reaches the index.
    assign w_wr_off      = r_aw_addr - BASE_ADDR;
    assign w_rd_off      = r_ar_addr - BASE_ADDR;
    assign w_wr_in_range = (r_aw_addr >= BASE_ADDR) && (w_wr_off < SPAN);
    assign w_rd_in_range = (r_ar_addr >= BASE_ADDR) && (w_rd_off < SPAN);
    assign w_wr_idx      = w_wr_off[IDX_W+1:2];
    assign w_rd_idx      = w_rd_off[IDX_W+1:2];
    assign w_mem_we      = (r_wstate == W_COMMIT) && w_wr_in_range && !rst;

    assign w_unused = ^{s_axi_aw_prot, s_axi_ar_prot, w_wr_off, w_rd_off};

    // Write FSM: next state
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:   if (w_aw_have && w_w_have) w_wstate_nxt = W_COMMIT;
            W_COMMIT: w_wstate_nxt = W_RESP;
            W_RESP:   if (s_axi_b_ready) w_wstate_nxt = W_IDLE;
            default:  w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM: next values of latch flags and registered outputs
    always_comb begin
        w_aw_lat_nxt = r_aw_lat;
        w_w_lat_nxt  = r_w_lat;
        w_b_resp_nxt = r_b_resp;
        case (r_wstate)
            W_IDLE: begin
                w_aw_lat_nxt = w_aw_have;
                w_w_lat_nxt  = w_w_have;
            end
            W_COMMIT: w_b_resp_nxt = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            W_RESP: begin
                if (s_axi_b_ready) begin
                    w_aw_lat_nxt = 1'b0;
                    w_w_lat_nxt  = 1'b0;
                end
            end
            default: begin
                w_aw_lat_nxt = 1'b0;
                w_w_lat_nxt  = 1'b0;
            end
        endcase
        w_aw_ready_nxt = (w_wstate_nxt == W_IDLE) && !w_aw_lat_nxt;
        w_w_ready_nxt  = (w_wstate_nxt == W_IDLE) && !w_w_lat_nxt;
        w_b_valid_nxt  = (w_wstate_nxt == W_RESP);
    end

    // Write FSM: state and output registers
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_wstate   <= W_IDLE;
            r_aw_lat   <= 1'b0;
            r_w_lat    <= 1'b0;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_wr_count <= 16'd0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_aw_lat   <= w_aw_lat_nxt;
            r_w_lat    <= w_w_lat_nxt;
            r_aw_ready <= w_aw_ready_nxt;
            r_w_ready  <= w_w_ready_nxt;
            r_b_valid  <= w_b_valid_nxt;
            r_b_resp   <= w_b_resp_nxt;
            if (w_mem_we) r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // Request payload capture; the latch flags decide whether it is meaningful
    always_ff @(posedge aclk) begin
        if (w_aw_hs) r_aw_addr <= s_axi_aw_addr;
        if (w_w_hs) begin
            r_w_data <= s_axi_w_data;
            r_w_strb <= s_axi_w_strb;
        end
        if (w_ar_hs) r_ar_addr <= s_axi_ar_addr;
    end

    // Byte-masked RAM write; contents deliberately survive reset
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (r_w_strb[b]) r_mem[w_wr_idx][b*8 +: 8] <= r_w_data[b*8 +: 8];
            end
        end
    end

    // Read FSM: next state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_MEM;
            R_MEM:   w_rstate_nxt = R_RESP;
            R_RESP:  if (s_axi_r_ready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM: next values of registered outputs
    always_comb begin
        w_r_resp_nxt = r_r_resp;
        if (r_rstate == R_MEM) w_r_resp_nxt = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        w_ar_ready_nxt = (w_rstate_nxt == R_IDLE);
        w_r_valid_nxt  = (w_rstate_nxt == R_RESP);
    end

    // Read FSM registers; the R_MEM read samples the pre-write word on a collision
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_resp   <= RESP_OKAY;
            r_r_data   <= '0;
        end else begin
            r_rstate   <= w_rstate_nxt;
            r_ar_ready <= w_ar_ready_nxt;
            r_r_valid  <= w_r_valid_nxt;
            r_r_resp   <= w_r_resp_nxt;
            if (r_rstate == R_MEM) r_r_data <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
        end
    end

    assign s_axi_aw_ready = r_aw_ready;
    assign s_axi_w_ready  = r_w_ready;
    assign s_axi_b_valid  = r_b_valid;
    assign s_axi_b_resp   = r_b_resp;
    assign s_axi_ar_ready = r_ar_ready;
    assign s_axi_r_valid  = r_r_valid;
    assign s_axi_r_resp   = r_r_resp;
    assign s_axi_r_data   = r_r_data;
    assign wr_count       = r_wr_count;

endmodule

// File: tb/tb_axil_resp_mem.sv
// Directed bench for axil_resp_mem: exact handshake timing, decode, strobes, backpressure, collision, reset.
`timescale 1ns/1ps
module tb_axil_resp_mem;

    logic        aclk;
    logic        rst;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    axil_resp_mem u_dut (
        .aclk           (aclk),
        .rst            (rst),
        .s_axi_aw_addr  (aw_addr),
        .s_axi_aw_prot  (aw_prot),
        .s_axi_aw_valid (aw_valid),
        .s_axi_aw_ready (aw_ready),
        .s_axi_w_data   (w_data),
        .s_axi_w_strb   (w_strb),
        .s_axi_w_valid  (w_valid),
        .s_axi_w_ready  (w_ready),
        .s_axi_b_resp   (b_resp),
        .s_axi_b_valid  (b_valid),
        .s_axi_b_ready  (b_ready),
        .s_axi_ar_addr  (ar_addr),
        .s_axi_ar_prot  (ar_prot),
        .s_axi_ar_valid (ar_valid),
        .s_axi_ar_ready (ar_ready),
        .s_axi_r_data   (r_data),
        .s_axi_r_resp   (r_resp),
        .s_axi_r_valid  (r_valid),
        .s_axi_r_ready  (r_ready),
        .wr_count       (wr_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output logic ok);
        logic aw_done, w_done, got_b, hs_aw, hs_w;
        aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0; resp = 2'b11;
        aw_addr = addr; w_data = data; w_strb = strb;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            hs_aw = aw_valid && aw_ready;
            hs_w  = w_valid && w_ready;
            tick();
            if (hs_aw) begin aw_valid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin w_valid  = 1'b0; w_done  = 1'b1; end
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (b_valid) begin got_b = 1'b1; resp = b_resp; end
            tick();
        end
        ok = aw_done && w_done && got_b;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic ok);
        logic ar_done, got_r, hs_ar;
        ar_done = 1'b0; got_r = 1'b0; data = 32'hdead_dead; resp = 2'b11;
        ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            hs_ar = ar_valid && ar_ready;
            tick();
            if (hs_ar) begin ar_valid = 1'b0; ar_done = 1'b1; end
        end
        ar_valid = 1'b0;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (r_valid) begin got_r = 1'b1; data = r_data; resp = r_resp; end
            tick();
        end
        ok = ar_done && got_r;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] resp;
        logic       ok;
        axi_write(addr, data, strb, resp, ok);
        check({tag, "_done"}, 32'(ok), 32'd1);
        check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
    endtask

    task automatic rd(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] data;
        logic [1:0]  resp;
        logic        ok;
        axi_read(addr, data, resp, ok);
        check({tag, "_done"}, 32'(ok), 32'd1);
        check({tag, "_rdata"}, data, exp_data);
        check({tag, "_rresp"}, 32'(resp), 32'(exp_resp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        aw_addr = '0; aw_prot = 3'b000; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b1;
        ar_addr = '0; ar_prot = 3'b000; ar_valid = 1'b0; r_ready = 1'b1;
        repeat (3) tick();

        // reset state
        check("rst_aw_ready", 32'(aw_ready), 32'd0);
        check("rst_w_ready", 32'(w_ready), 32'd0);
        check("rst_ar_ready", 32'(ar_ready), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_b_resp", 32'(b_resp), 32'd0);
        check("rst_r_resp", 32'(r_resp), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_aw_ready", 32'(aw_ready), 32'd1);
        check("post_rst_w_ready", 32'(w_ready), 32'd1);
        check("post_rst_ar_ready", 32'(ar_ready), 32'd1);

        // same-cycle AW/W, exact write latency
        aw_addr = 32'h7000_0000; w_data = 32'hcafe_cafe; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        check("t1_commit_aw_ready", 32'(aw_ready), 32'd0);
        check("t1_commit_b_valid", 32'(b_valid), 32'd0);
        tick();
        check("t1_b_valid", 32'(b_valid), 32'd1);
        check("t1_b_resp", 32'(b_resp), 32'd0);
        check("t1_wr_count", 32'(wr_count), 32'd1);
        tick();
        check("t1_b_done", 32'(b_valid), 32'd0);
        check("t1_aw_ready_back", 32'(aw_ready), 32'd1);

        // exact read latency
        ar_addr = 32'h7000_0000; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        check("t1_rmem_r_valid", 32'(r_valid), 32'd0);
        check("t1_rmem_ar_ready", 32'(ar_ready), 32'd0);
        tick();
        check("t1_r_valid", 32'(r_valid), 32'd1);
        check("t1_r_data", r_data, 32'hcafe_cafe);
        check("t1_r_resp", 32'(r_resp), 32'd0);
        tick();
        check("t1_r_done", 32'(r_valid), 32'd0);
        check("t1_ar_ready_back", 32'(ar_ready), 32'd1);

        // W three cycles before AW
        w_data = 32'h1111_1111; w_strb = 4'hF; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        check("t2a_w_ready", 32'(w_ready), 32'd0);
        check("t2a_aw_ready", 32'(aw_ready), 32'd1);
        tick();
        tick();
        aw_addr = 32'h7000_0004; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        tick();
        check("t2a_b_valid", 32'(b_valid), 32'd1);
        check("t2a_b_resp", 32'(b_resp), 32'd0);
        tick();

        // AW two cycles before W
        aw_addr = 32'h7000_0008; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        check("t2b_aw_ready", 32'(aw_ready), 32'd0);
        check("t2b_w_ready", 32'(w_ready), 32'd1);
        tick();
        w_data = 32'h2222_2222; w_strb = 4'hF; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        tick();
        check("t2b_b_valid", 32'(b_valid), 32'd1);
        check("t2b_b_resp", 32'(b_resp), 32'd0);
        check("t2b_wr_count", 32'(wr_count), 32'd3);
        tick();
        rd("t2_rd8", 32'h7000_0008, 32'h2222_2222, 2'b00);
        rd("t2_rd4", 32'h7000_0004, 32'h1111_1111, 2'b00);

        // partial strobes; low address bits ignored
        wr("t3_full", 32'h7000_000C, 32'hffff_ffff, 4'hF, 2'b00);
        wr("t3_part", 32'h7000_000C, 32'h0000_beef, 4'h3, 2'b00);
        rd("t3_rd", 32'h7000_000C, 32'hffff_beef, 2'b00);
        rd("t3_rd_unaligned", 32'h7000_000F, 32'hffff_beef, 2'b00);
        check("t3_wr_count", 32'(wr_count), 32'd5);

        // out of range above, below, and the last valid word
        wr("t4_wr_oor", 32'h7000_0400, 32'h5555_5555, 4'hF, 2'b10);
        check("t4_wr_count_oor", 32'(wr_count), 32'd5);
        rd("t4_rd_oor", 32'h7000_0400, 32'h0000_0000, 2'b10);
        rd("t4_rd_below", 32'h6fff_fffc, 32'h0000_0000, 2'b10);
        rd("t4_word0", 32'h7000_0000, 32'hcafe_cafe, 2'b00);
        wr("t4_wr_last", 32'h7000_03FC, 32'h1234_5678, 4'hF, 2'b00);
        rd("t4_rd_last", 32'h7000_03FC, 32'h1234_5678, 2'b00);
        check("t4_wr_count_last", 32'(wr_count), 32'd6);

        // write backpressure
        b_ready = 1'b0;
        aw_addr = 32'h7000_0010; w_data = 32'ha5a5_a5a5; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_b_valid_hold", 32'(b_valid), 32'd1);
            check("t5_b_resp_hold", 32'(b_resp), 32'd0);
            check("t5_aw_ready_hold", 32'(aw_ready), 32'd0);
            tick();
        end
        b_ready = 1'b1;
        tick();
        check("t5_b_done", 32'(b_valid), 32'd0);
        check("t5_wr_count", 32'(wr_count), 32'd7);
        tick();
        check("t5_b_once", 32'(b_valid), 32'd0);

        // read backpressure
        r_ready = 1'b0;
        ar_addr = 32'h7000_0010; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_r_valid_hold", 32'(r_valid), 32'd1);
            check("t5_r_data_hold", r_data, 32'ha5a5_a5a5);
            check("t5_ar_ready_hold", 32'(ar_ready), 32'd0);
            tick();
        end
        r_ready = 1'b1;
        tick();
        check("t5_r_done", 32'(r_valid), 32'd0);
        tick();
        check("t5_r_once", 32'(r_valid), 32'd0);

        // same-cycle collision: read sees the old word
        wr("t6_init", 32'h7000_0014, 32'h0000_0001, 4'hF, 2'b00);
        aw_addr = 32'h7000_0014; w_data = 32'h0000_0002; w_strb = 4'hF;
        ar_addr = 32'h7000_0014;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        tick();
        check("t6_r_valid", 32'(r_valid), 32'd1);
        check("t6_b_valid", 32'(b_valid), 32'd1);
        check("t6_r_data_old", r_data, 32'h0000_0001);
        tick();
        rd("t6_rd_new", 32'h7000_0014, 32'h0000_0002, 2'b00);
        check("t6_wr_count", 32'(wr_count), 32'd9);

        // reset while a write response is pending
        b_ready = 1'b0;
        aw_addr = 32'h7000_0018; w_data = 32'h7777_0000; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        tick();
        check("t7_b_valid", 32'(b_valid), 32'd1);
        check("t7_wr_count", 32'(wr_count), 32'd10);
        rst = 1'b1;
        tick();
        check("t7_rst_b_valid", 32'(b_valid), 32'd0);
        check("t7_rst_wr_count", 32'(wr_count), 32'd0);
        check("t7_rst_aw_ready", 32'(aw_ready), 32'd0);
        rst = 1'b0;
        b_ready = 1'b1;
        tick();
        check("t7_aw_ready", 32'(aw_ready), 32'd1);
        check("t7_b_quiet", 32'(b_valid), 32'd0);
        rd("t7_rd_kept", 32'h7000_0018, 32'h7777_0000, 2'b00);
        rd("t7_rd_word0", 32'h7000_0000, 32'hcafe_cafe, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_resp_mem.md
# axil_resp_mem

AXI4-Lite slave memory responder that terminates the `m_axi_*` master port of `mcore_top`, replacing the tied-off ready/valid stubs with a real backing store. It accepts single-beat writes and reads into a word-addressed on-chip RAM and returns OKAY/SLVERR responses. It is used in simulation and on fabric to capture and replay mcore DMA/util-engine traffic, for example a fill at `0x7000_0000`. One transaction per channel is outstanding at a time; the read and write channels operate independently.

## Interface
- `DATA_WIDTH`, 32, AXI data width; byte strobes are `DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32, AXI address width.
- `BASE_ADDR`, 32'h7000_0000, byte address of word 0.
- `DEPTH_WORDS`, 256, RAM depth in words; must be a power of 2.

Ports:
- `aclk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axi_aw_addr`  in  ADDR_WIDTH  write address.
- `s_axi_aw_prot`  in  3  ignored.
- `s_axi_aw_valid` in / `s_axi_aw_ready` out  1  write-address handshake.
- `s_axi_w_data`  in  DATA_WIDTH  write data.
- `s_axi_w_strb`  in  DATA_WIDTH/8  byte enables.
- `s_axi_w_valid` in / `s_axi_w_ready` out  1  write-data handshake.
- `s_axi_b_resp`  out  2  2'b00 OKAY, 2'b10 SLVERR.
- `s_axi_b_valid` out / `s_axi_b_ready` in  1  write-response handshake.
- `s_axi_ar_addr`  in  ADDR_WIDTH  read address.
- `s_axi_ar_prot`  in  3  ignored.
- `s_axi_ar_valid` in / `s_axi_ar_ready` out  1  read-address handshake.
- `s_axi_r_data`  out  DATA_WIDTH  read data.
- `s_axi_r_resp`  out  2  read response.
- `s_axi_r_valid` out / `s_axi_r_ready` in  1  read-data handshake.
- `wr_count`  out  16  count of committed OKAY writes; wraps at 16 bits.

## Operation
- Decode:
  - offset = addr − BASE_ADDR.
  - In range when BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH_WORDS.
  - Word index = offset[log2(DEPTH_WORDS)+1:2]; addr[1:0] is ignored.
- Write FSM has three states:
  - W_IDLE: `aw_ready` is high until AW is latched, and `w_ready` is high until W is latched. AW and W may arrive in either order or in the same cycle.
  - When both are latched, go to W_COMMIT.
  - W_COMMIT (exactly 1 cycle):
    - In range: write the RAM bytes where strb=1 and increment `wr_count`.
    - Out of range: no RAM write and no count. Then go to W_RESP.
  - W_RESP: `b_valid`=1 and `b_resp` is set from the decode. Hold until `b_ready`, then return to W_IDLE with the latch flags cleared.
- Read FSM has three states:
  - R_IDLE: `ar_ready`=1. On handshake, latch the address and go to R_MEM.
  - R_MEM (1 cycle): synchronous RAM read, then go to R_RESP.
  - R_RESP: `r_valid`=1. `r_data` is the RAM word, or 0 if out of range. `r_resp` is OKAY or SLVERR. Hold until `r_ready`, then go to R_IDLE.
- Collision: if W_COMMIT and R_MEM hit the same word in the same cycle, the read returns the old data (read-first).
- While in R_RESP or W_RESP, `r_data`, `r_resp` and `b_resp` stay stable until the handshake completes.
- Reset:
  - Both FSMs go to IDLE and the latch flags clear.
  - `wr_count`=0.
  - RAM contents are retained; they are not cleared.
  - Any in-flight transaction is dropped and no response is issued.

## Timing
- Reset values:
  - During `rst`: `aw_ready`=`w_ready`=`ar_ready`=0.
  - After `rst` is released: the ready outputs are high in the first cycle.
  - `b_valid`=`r_valid`=0, `b_resp`=`r_resp`=0, `r_data`=0, `wr_count`=0.
- All outputs are registered; there is no combinational path from input to output.
- Write latency: last of AW/W handshake at edge N → RAM write at edge N+1 → `b_valid` high after edge N+1 → `aw_ready`/`w_ready` high after the edge on which B is accepted.
- Read latency: AR at edge N → `r_valid` high after edge N+2.
- With `b_ready` and `r_ready` tied high:
  - Write throughput is 1 transaction per 3 cycles.
  - Read throughput is 1 transaction per 3 cycles.
- Ready is deasserted after the handshake edge, so a valid held high across cycles is never accepted twice.
- Reset mid-operation takes effect at the next edge, and `rst` overrides any handshake on that edge.

## Test plan
- Write `0x7000_0000` ← `cafe_cafe` with strb=4'hF and AW/W in the same cycle.
  - `b_valid` appears 1 cycle later with OKAY, and `wr_count`=1.
  - A read of `0x7000_0000` gives `r_valid` 2 cycles after AR with data `cafe_cafe`.
- Write W 3 cycles before AW, then AW 2 cycles before W.
  - Both complete with OKAY.
  - The readback at `0x7000_0008` matches the last write.
- Partial strobe: write `ffff_ffff`, then write `0000_beef` with strb=4'h3.
  - The readback is `ffff_beef`.
- Out of range: write and read at `0x7000_0400` with DEPTH_WORDS=256.
  - Both responses are SLVERR, `r_data`=0 and `wr_count` is unchanged.
  - Word 0 is unaffected.
- Backpressure: hold `b_ready`/`r_ready` low for 5 cycles.
  - `b_valid`/`r_valid` and their data stay stable and `aw_ready`/`ar_ready` stay 0.
  - Each response completes exactly once when ready rises.
- Same-cycle collision returns the old word.
- Assert `rst` in W_RESP:
  - `b_valid` drops and `wr_count`=0.
  - A prior RAM write is still readable.
